// File: rtl/mem_responder.sv
// Memory-side responder: one outstanding word request, configurable wait states,
// byte-lane writes / word reads on internal storage, response held until taken.
module mem_responder #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int unsigned CNT_INIT = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_n;
    logic               accept_c;
    logic               enter_resp_c;

    logic               lat_we;
    logic [31:0]        lat_addr;
    logic [31:0]        lat_wdata;
    logic [3:0]         lat_be;

    logic               cur_we;
    logic [31:0]        cur_addr;
    logic [31:0]        cur_wdata;
    logic [3:0]         cur_be;
    logic               err_c;
    logic [IDX_W-1:0]   idx_c;

    logic [31:0]        mem [DEPTH_WORDS];

    assign req_ready = rst && (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    // With zero wait states the storage access happens on the accept edge,
    // so the live request is used instead of the latched copy.
    always_comb begin
        if (state == IDLE) begin
            cur_we    = req_we;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
            cur_be    = req_be;
        end else begin
            cur_we    = lat_we;
            cur_addr  = lat_addr;
            cur_wdata = lat_wdata;
            cur_be    = lat_be;
        end
        err_c = (cur_addr[1:0] != 2'b00) || (cur_addr[31:2] >= 30'(DEPTH_WORDS));
        idx_c = cur_addr[IDX_W+1:2];
    end

    // Next-state logic
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        accept_c     = 1'b0;
        enter_resp_c = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    accept_c = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_n      = RESP;
                        enter_resp_c = 1'b1;
                    end else begin
                        state_n = WAIT;
                        cnt_n   = CNT_W'(CNT_INIT);
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_n      = RESP;
                    enter_resp_c = 1'b1;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State register and held response
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (enter_resp_c) begin
                rsp_err   <= err_c;
                rsp_rdata <= (cur_we || err_c) ? 32'h0 : mem[idx_c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept_c) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_be    <= req_be;
        end
    end

    // Storage survives reset; a write is committed only on entry to RESP
    always_ff @(posedge clk) begin
        if (rst && enter_resp_c && cur_we && !err_c) begin
            for (int i = 0; i < 4; i++) begin
                if (cur_be[i]) begin
                    mem[idx_c][8*i +: 8] <= cur_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule
